// File: rtl/foc_pkg.sv
// Shared constants, state encoding and helpers for the FOC transform blocks.
package foc_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned KW    = 10;
    localparam int unsigned SW    = DW + 2;
    localparam int unsigned ACC_W = 28;

    localparam logic [KW-1:0] K_INV_SQRT3 = 10'd591;
    localparam logic [KW-1:0] K_SQRT3_2   = 10'd886;

    localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = SW'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } clark_state_e;

    // Clamp an SW-bit signed value into the DW-bit signed range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] x);
        if (x > SAT_HI) begin
            return DW'(SAT_HI);
        end else if (x < SAT_LO) begin
            return DW'(SAT_LO);
        end
        return DW'(x);
    endfunction

endpackage

// File: rtl/clark_seqmul.sv
// Signed x unsigned-constant shift-add multiplier, one constant bit per cycle.
// Product is returned arithmetically shifted right by FRAC and truncated to OW bits.
module clark_seqmul #(
    parameter int unsigned AW   = 18,
    parameter int unsigned PW   = 28,
    parameter int unsigned KW   = 10,
    parameter int unsigned FRAC = 10,
    parameter int unsigned OW   = 18,
    parameter logic [KW-1:0] K  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic signed [AW-1:0] a_i,
    output logic                 done_c_o,
    output logic signed [OW-1:0] p_o
);

    localparam int unsigned CW = $clog2(KW);

    logic                 run_q,   run_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic signed [AW-1:0] a_q,     a_d;
    logic signed [PW-1:0] acc_q,   acc_d;

    // Accumulate one shifted partial product per constant bit.
    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        a_d   = a_q;
        acc_d = acc_q;
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = '0;
            a_d   = a_i;
            acc_d = '0;
        end else if (run_q) begin
            if (K[cnt_q]) begin
                acc_d = acc_q + (PW'(a_q) <<< cnt_q);
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(KW - 1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            a_q   <= '0;
            acc_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            a_q   <= a_d;
            acc_q <= acc_d;
        end
    end

    assign done_c_o = run_q && (cnt_q == CW'(KW - 1));
    assign p_o      = OW'(acc_q >>> FRAC);

endmodule

// File: rtl/clark.sv
// Forward Clarke transform: Ialpha = Ia, Ibeta = (Ia + 2*Ib)/sqrt(3) via iterative multiply.
// Define CLARK_SAT_EN to saturate Ibeta instead of wrapping it.
module clark
    import foc_pkg::*;
(
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iC_en,
    input  logic signed [DW-1:0] iIa,
    input  logic signed [DW-1:0] iIb,
    output logic signed [DW-1:0] oIalpha,
    output logic signed [DW-1:0] oIbeta,
    output logic                 oBusy,
    output logic                 oC_done
);

    clark_state_e         state_q, state_d;
    logic                 en_q;
    logic signed [DW-1:0] alpha_q, alpha_d;
    logic signed [DW-1:0] ialpha_q, ialpha_d;
    logic signed [DW-1:0] ibeta_q, ibeta_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_c;
    logic                 mul_start_c;
    logic                 mul_done_c;
    logic signed [SW-1:0] sum_c;
    logic signed [DW-1:0] beta_c;

    assign start_c = iC_en & ~en_q;
    assign sum_c   = SW'(iIa) + (SW'(iIb) <<< 1);

`ifdef CLARK_SAT_EN
    localparam int unsigned BW = SW;
    logic signed [BW-1:0] prod_c;
    assign beta_c = sat_dw(prod_c);
`else
    localparam int unsigned BW = DW;
    logic signed [BW-1:0] prod_c;
    assign beta_c = prod_c;
`endif

    clark_seqmul #(
        .AW   (SW),
        .PW   (ACC_W),
        .KW   (KW),
        .FRAC (KW),
        .OW   (BW),
        .K    (K_INV_SQRT3)
    ) u_mul (
        .clk      (iClk),
        .rst_n    (iRst_n),
        .start_i  (mul_start_c),
        .a_i      (sum_c),
        .done_c_o (mul_done_c),
        .p_o      (prod_c)
    );

    always_comb begin
        state_d     = state_q;
        alpha_d     = alpha_q;
        ialpha_d    = ialpha_q;
        ibeta_d     = ibeta_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        mul_start_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d     = MUL;
                    alpha_d     = iIa;
                    mul_start_c = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            MUL: begin
                busy_d = 1'b1;
                if (mul_done_c) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                ialpha_d = alpha_q;
                ibeta_d  = beta_c;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            alpha_q  <= '0;
            ialpha_q <= '0;
            ibeta_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= iC_en;
            alpha_q  <= alpha_d;
            ialpha_q <= ialpha_d;
            ibeta_q  <= ibeta_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oIalpha = ialpha_q;
    assign oIbeta  = ibeta_q;
    assign oBusy   = busy_q;
    assign oC_done = done_q;

endmodule

// File: doc/clark.md
Name: clark

Overview:
- Forward Clarke transform. Converts two sampled phase currents (Ia, Ib; Ic implied by Ia+Ib+Ic=0) into stationary-frame Ialpha/Ibeta.
- Sits between the current-sense ADC front end and the Park transform in the FOC current loop.
- Amplitude-invariant form: Ialpha = Ia, Ibeta = (Ia + 2·Ib)·(1/√3).
- Uses an iterative shift-add multiplier (one constant bit per cycle) instead of a DSP multiply, so it has fixed multi-cycle latency and a busy window.

Parameters:
- DW, 16, data width of phase inputs and alpha/beta outputs (signed two's complement).
- KW, 10, width of the fractional constant; scale is 2^KW.
- K_INV_SQRT3, 591, round(1/√3 · (2^10−1)); unsigned, KW bits.

Ports:
- iClk  in  1  clock; all state on rising edge.
- iRst_n  in  1  asynchronous, active-low reset.
- iC_en  in  1  start request; acts on its rising edge only.
- iIa  in  DW  phase A current, signed.
- iIb  in  DW  phase B current, signed.
- oIalpha  out  DW  alpha current, signed.
- oIbeta  out  DW  beta current, signed.
- oBusy  out  1  high while a conversion is in progress.
- oC_done  out  1  one-cycle pulse when new outputs are valid.

Behaviour:
- Reset (async, iRst_n=0): oIalpha=0, oIbeta=0, oBusy=0, oC_done=0, FSM=IDLE, edge register=0, accumulator=0, bit counter=0.
- Edge detect: a register holds the previous iC_en every cycle, in all states. Start = iC_en & !prev.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - On start, latch sum = iIa + 2·iIb, sign-extended to DW+2 (18) bits. No overflow is possible at this width.
  - Latch alpha = iIa; clear the 28-bit accumulator; set counter=0; go to MUL; oBusy=1 from the next cycle.
- MUL: runs KW cycles, k = 0..KW−1.
  - If K_INV_SQRT3[k]=1, acc += sum <<< k, signed, 28 bits.
  - Counter increments each cycle. After k=KW−1, go to DONE.
- DONE (single cycle):
  - oIalpha ← latched alpha.
  - oIbeta ← (acc >>> KW)[DW−1:0] (arithmetic shift; truncation toward −∞).
  - oC_done=1 for this cycle; oBusy=0; return to IDLE.
- Latency: start sampled at edge N; outputs and oC_done are visible after edge N+KW+1 (11 cycles for KW=10). Throughput is one conversion per KW+2 cycles minimum.
- Starts while busy (MUL/DONE) are ignored and not queued. Input changes during MUL have no effect because the operands are latched.
- iC_en held high does not retrigger; it must fall and rise again.
- Outputs hold their values between conversions.
- Reset asserted mid-conversion aborts immediately to reset values; no oC_done is produced.

Optional Feature:
- Macro CLARK_SAT_EN.
- Defined: the shifted beta result (18 significant bits) is saturated to [−2^(DW−1), 2^(DW−1)−1] before assignment.
- Undefined: low DW bits are taken with two's-complement wrap. This is the default and matches the existing transform blocks.
- Alpha is unaffected in both cases.

Decomposition:
- Shared package foc_pkg holds:
  - K_INV_SQRT3 and the existing K_SQRT3_2 (886).
  - DW, KW.
  - clark state enum {IDLE, MUL, DONE}.
- One natural sub-module: clark_seqmul. It is a signed×unsigned-constant shift-add multiplier with start, done, operand and product ports, reusable later for the Park transform.

Test Plan:
- Reset then Ia=1000, Ib=−500, rising iC_en → after 11 cycles oC_done pulses once; oIalpha=1000, oIbeta=0; oBusy high for exactly the 10 MUL cycles.
- Ia=0, Ib=1000 → oIbeta=1154. Then Ia=0, Ib=−1000 → oIbeta=−1155 (floor behaviour).
- Ia=Ib=32767 → oIbeta=32767 with CLARK_SAT_EN, −8802 without. Ia=Ib=−32768 → −32768 with, 8800 without.
- iC_en held high for 30 cycles → exactly one oC_done. A second rising edge during MUL → ignored, no second done. Change iIa/iIb mid-MUL → result uses the latched values.
- Assert iRst_n=0 at MUL cycle 5 → all outputs 0 immediately, no done. After release, a new start completes normally with 11-cycle latency.
